decode_interchange_scheduler: RTL and testbench

//  Sequencing buffer between the 4-lane decoder and the instruction interchange.

---
 rtl/decode_interchange_scheduler.sv | 89 ++++++++
 tb/tb_decode_interchange_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/decode_interchange_scheduler.sv
// decode_interchange_scheduler: in-order queue from the 4-lane decoder to the 2-slot interchange (optional SCHED_STATS_EN adds stall/issue counters)
module decode_interchange_scheduler #(
    parameter int payloadWidth = 128,
    parameter int depth        = 8,
    parameter int ptrWidth     = 3
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic [3:0]                enable_i,
    input  logic [4*payloadWidth-1:0] payload_i,
    output logic                      stall_o,
    output logic [1:0]                issueValid_o,
    output logic [2*payloadWidth-1:0] issuePayload_o,
    input  logic [1:0]                issueReady_i,
    output logic [ptrWidth:0]         occupancy_o
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]               stallCycles_o,
    output logic [63:0]               issuedCount_o
`endif
);
    typedef logic [ptrWidth-1:0] ptr_t;
    typedef logic [ptrWidth:0]   cnt_t;
    logic [payloadWidth-1:0] mem_q [depth];
    logic [payloadWidth-1:0] mem_d [depth];
    ptr_t head_q, head_d, tail_q, tail_d, head1;
    cnt_t count_q, count_d;
    logic pop0, pop1;
    logic [1:0] pops;
    logic [2:0] writes;
`ifdef SCHED_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [63:0] issued_q, issued_d;
`endif
    // Issue view, handshake pops, lane compaction into the tail and next-state pointers
    always_comb begin
        stall_o = (depth - int'(count_q)) < 4;
        issueValid_o = {count_q >= cnt_t'(2), count_q >= cnt_t'(1)};
        pop0 = issueValid_o[0] & issueReady_i[0];
        pop1 = issueValid_o[1] & issueReady_i[1] & pop0;
        pops = {1'b0, pop0} + {1'b0, pop1};
        head1 = head_q + ptr_t'(1);
        issuePayload_o[0 +: payloadWidth] = issueValid_o[0] ? mem_q[head_q] : '0;
        issuePayload_o[payloadWidth +: payloadWidth] = issueValid_o[1] ? mem_q[head1] : '0;
        mem_d = mem_q;
        writes = '0;
        for (int n = 0; n < 4; n++) begin
            if (!stall_o && !flush_i && enable_i[n]) begin
                mem_d[tail_q + ptr_t'(writes)] = payload_i[n*payloadWidth +: payloadWidth];
                writes = writes + 3'd1;
            end
        end
        head_d = flush_i ? '0 : head_q + ptr_t'(pops);
        tail_d = flush_i ? '0 : tail_q + ptr_t'(writes);
        count_d = flush_i ? '0 : count_q + cnt_t'(writes) - cnt_t'(pops);
        occupancy_o = count_q;
`ifdef SCHED_STATS_EN
        stall_cnt_d = (stall_o && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        issued_d = issued_q + 64'(pops);
        stallCycles_o = stall_cnt_q;
        issuedCount_o = issued_q;
`endif
    end
    // Queue pointers and counters; reset clears everything, flush only the queue
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
`ifdef SCHED_STATS_EN
            stall_cnt_q <= '0;
            issued_q <= '0;
`endif
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
`ifdef SCHED_STATS_EN
            stall_cnt_q <= stall_cnt_d;
            issued_q <= issued_d;
`endif
        end
    end
    // Entry storage; contents are don't-care until counted, so no reset
    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_decode_interchange_scheduler.sv
// tb_decode_interchange_scheduler: queue-model checker plus directed pins for decode_interchange_scheduler
module tb_decode_interchange_scheduler;
    localparam int W = 128;
    logic clock_i = 0, reset_i = 1, flush_i = 0;
    logic [3:0] enable_i = '0;
    logic [4*W-1:0] payload_i = '0;
    logic stall_o;
    logic [1:0] issueValid_o;
    logic [2*W-1:0] issuePayload_o;
    logic [1:0] issueReady_i = '0;
    logic [3:0] occupancy_o;
    int checks = 0, errors = 0;
    logic [W-1:0] mq[$];

    decode_interchange_scheduler dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
        .payload_i(payload_i), .stall_o(stall_o), .issueValid_o(issueValid_o),
        .issuePayload_o(issuePayload_o), .issueReady_i(issueReady_i), .occupancy_o(occupancy_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [W-1:0] mk(int id);
        return {4{32'(id)}};
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Reference queue: at most 2 in-order pops, then append enabled lanes unless stalled; flush empties
    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i) mq.delete();
        else begin
            automatic bit st = (8 - mq.size()) < 4;
            automatic int np = 0;
            if (mq.size() >= 1 && issueReady_i[0]) np = (mq.size() >= 2 && issueReady_i[1]) ? 2 : 1;
            if (flush_i) mq.delete();
            else begin
                repeat (np) void'(mq.pop_front());
                if (!st) for (int n = 0; n < 4; n++) if (enable_i[n]) mq.push_back(payload_i[n*W +: W]);
            end
        end
    end

    // Every cycle out of reset, outputs must match the reference queue
    always @(negedge clock_i) begin
        if (!reset_i) begin
            chk("m_occ", W'(occupancy_o), W'(mq.size()));
            chk("m_stall", W'(stall_o), W'((8 - mq.size()) < 4));
            chk("m_valid", W'(issueValid_o), W'({mq.size() >= 2, mq.size() >= 1}));
            chk("m_slot0", issuePayload_o[0 +: W], mq.size() >= 1 ? mq[0] : '0);
            chk("m_slot1", issuePayload_o[W +: W], mq.size() >= 2 ? mq[1] : '0);
        end
    end

    task automatic drive(logic [3:0] en, int i0, int i1, int i2, int i3, logic [1:0] rdy, logic fl);
        enable_i = en;
        payload_i = {mk(i3), mk(i2), mk(i1), mk(i0)};
        issueReady_i = rdy;
        flush_i = fl;
        @(posedge clock_i);
        #1;
    endtask

    task automatic pin(string nm, int occ, logic [1:0] v, logic st, int s0);
        chk({nm, "_occ"}, W'(occupancy_o), W'(occ));
        chk({nm, "_valid"}, W'(issueValid_o), W'(v));
        chk({nm, "_stall"}, W'(stall_o), W'(st));
        chk({nm, "_slot0"}, issuePayload_o[0 +: W], s0 < 0 ? '0 : mk(s0));
    endtask

    initial begin
        #12 reset_i = 0;
        pin("reset", 0, 2'b00, 0, -1);
        drive(4'b1111, 1, 2, 3, 4, 2'b00, 0);
        pin("fill4", 4, 2'b11, 0, 1);
        chk("fill4_slot1", issuePayload_o[W +: W], mk(2));
        drive(4'b1111, 5, 6, 7, 8, 2'b00, 0);
        pin("fill8", 8, 2'b11, 1, 1);
        drive(4'b1111, 9, 10, 11, 12, 2'b00, 0);
        pin("ignored", 8, 2'b11, 1, 1);
        drive(4'b0000, 0, 0, 0, 0, 2'b11, 0);
        pin("drain1", 6, 2'b11, 1, 3);
        drive(4'b0000, 0, 0, 0, 0, 2'b11, 0);
        pin("drain2", 4, 2'b11, 0, 5);
        drive(4'b0000, 0, 0, 0, 0, 2'b11, 0);
        pin("drain3", 2, 2'b11, 0, 7);
        chk("drain3_slot1", issuePayload_o[W +: W], mk(8));
        drive(4'b0000, 0, 0, 0, 0, 2'b11, 0);
        pin("drain4", 0, 2'b00, 0, -1);
        drive(4'b0101, 16, 99, 17, 98, 2'b00, 0);
        pin("compact", 2, 2'b11, 0, 16);
        chk("compact_slot1", issuePayload_o[W +: W], mk(17));
        drive(4'b0000, 0, 0, 0, 0, 2'b10, 0);
        pin("rdy1only", 2, 2'b11, 0, 16);
        drive(4'b0000, 0, 0, 0, 0, 2'b01, 0);
        pin("rdy0only", 1, 2'b01, 0, 17);
        drive(4'b0000, 0, 0, 0, 0, 2'b01, 0);
        drive(4'b1111, 20, 21, 22, 23, 2'b00, 0);
        drive(4'b0000, 0, 0, 0, 0, 2'b11, 0);
        drive(4'b0000, 0, 0, 0, 0, 2'b11, 0);
        pin("head6", 0, 2'b00, 0, -1);
        drive(4'b1111, 24, 25, 26, 27, 2'b00, 0);
        drive(4'b1010, 90, 28, 91, 29, 2'b00, 0);
        pin("wrap6", 6, 2'b11, 1, 24);
        drive(4'b0000, 0, 0, 0, 0, 2'b00, 0);
        drive(4'b0011, 30, 31, 0, 0, 2'b11, 0);
        pin("wrap_stalled", 4, 2'b11, 0, 26);
        drive(4'b0011, 30, 31, 0, 0, 2'b11, 0);
        pin("wrap_wr_pop", 4, 2'b11, 0, 28);
        chk("wrap_slot1", issuePayload_o[W +: W], mk(29));
        drive(4'b0000, 0, 0, 0, 0, 2'b11, 0);
        pin("wrap_tail", 2, 2'b11, 0, 30);
        drive(4'b0000, 0, 0, 0, 0, 2'b11, 0);
        drive(4'b1111, 40, 41, 42, 43, 2'b00, 0);
        drive(4'b1111, 50, 51, 52, 53, 2'b11, 1);
        pin("flush", 0, 2'b00, 0, -1);
        drive(4'b0011, 60, 61, 0, 0, 2'b00, 0);
        pin("post_flush", 2, 2'b11, 0, 60);
        drive(4'b1111, 70, 71, 72, 73, 2'b00, 0);
        drive(4'b0000, 0, 0, 0, 0, 2'b00, 0);
        pin("pre_reset", 6, 2'b11, 1, 60);
        #2 reset_i = 1;
        #1 pin("async_reset", 0, 2'b00, 0, -1);
        chk("async_slot1", issuePayload_o[W +: W], '0);
        #3 reset_i = 0;
        drive(4'b0001, 80, 0, 0, 0, 2'b00, 0);
        pin("after_reset", 1, 2'b01, 0, 80);
        drive(4'b0000, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clock_i);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
